// File: rtl/sfifo_buf.sv
`default_nettype none
// ============================================================================
// Module   : sfifo_buf
// Brief    : Synchronous first-word-fall-through FIFO with registered status
//            flags, sticky overflow/underflow flags and a base-period tick
//            generator.
// Revision : 1.0 - initial release
// ============================================================================
module sfifo_buf #(
  parameter int SFIFO_DW  = 16,
  parameter int AW        = 6,
  parameter int AF_MARGIN = 4,
  parameter int BP_W      = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wr_i,
  input  logic [SFIFO_DW-1:0] din_i,
  output logic                full_o,
  output logic                afull_o,
  input  logic                rd_i,
  output logic                empty_o,
  output logic [SFIFO_DW-1:0] dout_o,
  output logic [AW:0]         level_o,
  output logic                ovf_o,
  output logic                udf_o,
  input  logic                clr_err_i,
  input  logic                bp_en_i,
  input  logic [BP_W-1:0]     bp_period_i,
  output logic                bp_tick_o
);

  localparam int          DEPTH    = 2**AW;
  localparam logic [AW:0] C_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AF_LVL = (AW+1)'(DEPTH - AF_MARGIN);

  logic [SFIFO_DW-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wptr_q;
  logic [AW-1:0]       rptr_q;
  logic [AW:0]         level_q;
  logic [AW:0]         level_d;
  logic                empty_q;
  logic                full_q;
  logic                afull_q;
  logic                ovf_q;
  logic                ovf_d;
  logic                udf_q;
  logic                udf_d;
  logic [BP_W-1:0]     bp_cnt_q;
  logic                bp_tick_q;

  logic w_pop;
  logic w_push;
  logic w_ovf_ev;
  logic w_udf_ev;
  logic w_bp_hit;

  // A pop needs a stored word; a push may reuse the slot freed by a
  // same-cycle pop, so a full FIFO can stream. Reset masks both.
  assign w_pop    = rd_i & ~empty_q & ~wb_rst_i;
  assign w_push   = wr_i & (~full_q | w_pop) & ~wb_rst_i;
  assign w_ovf_ev = wr_i & full_q & ~w_pop;
  assign w_udf_ev = rd_i & empty_q;
  assign w_bp_hit = (bp_cnt_q >= bp_period_i);

  // Storage: one write port here, one asynchronous read address below.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  // Next word count and sticky error flags; a new event beats a clear.
  always_comb begin
    level_d = level_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    ovf_d = (ovf_q & ~clr_err_i) | w_ovf_ev;
    udf_d = (udf_q & ~clr_err_i) | w_udf_ev;
  end

  // Pointers, registered level/status flags and error flags.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (w_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (w_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == C_DEPTH);
      afull_q <= (level_d >= C_AF_LVL);
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Base-period counter: held at zero while disabled, restarts after a hit;
  // the >= compare means a lowered period fires at once instead of wrapping.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !bp_en_i) begin
      bp_cnt_q  <= '0;
      bp_tick_q <= 1'b0;
    end else if (w_bp_hit) begin
      bp_cnt_q  <= '0;
      bp_tick_q <= 1'b1;
    end else begin
      bp_cnt_q  <= bp_cnt_q + BP_W'(1);
      bp_tick_q <= 1'b0;
    end
  end

  assign dout_o    = mem_q[rptr_q];
  assign level_o   = level_q;
  assign empty_o   = empty_q;
  assign full_o    = full_q;
  assign afull_o   = afull_q;
  assign ovf_o     = ovf_q;
  assign udf_o     = udf_q;
  assign bp_tick_o = bp_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sfifo_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfifo_buf
// Brief    : Self-checking bench for sfifo_buf: directed vector table plus
//            hand-written fill/drain, streaming, tick and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfifo_buf;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst, wr, rd, clr, bp_en;
  logic [15:0] din, bp_period;
  logic        full, afull, empty, ovf, udf, tick;
  logic [15:0] dout;
  logic [6:0]  level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sfifo_buf dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wr_i        (wr),
    .din_i       (din),
    .full_o      (full),
    .afull_o     (afull),
    .rd_i        (rd),
    .empty_o     (empty),
    .dout_o      (dout),
    .level_o     (level),
    .ovf_o       (ovf),
    .udf_o       (udf),
    .clr_err_i   (clr),
    .bp_en_i     (bp_en),
    .bp_period_i (bp_period),
    .bp_tick_o   (tick)
  );

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic        clr;
    logic [15:0] din;
    logic [6:0]  lvl;
    logic        emp;
    logic        udf;
    logic        ovf;
    logic        dchk;
    logic [15:0] dout;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic r, input logic c,
                              input logic [15:0] d, input logic [6:0] l,
                              input logic e, input logic u, input logic o,
                              input logic dc, input logic [15:0] dv);
    vec_t v;
    v.wr = w; v.rd = r; v.clr = c; v.din = d; v.lvl = l;
    v.emp = e; v.udf = u; v.ovf = o; v.dchk = dc; v.dout = dv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock with the given request inputs; returns 1 time unit after the edge.
  task automatic drive(input logic w, input logic r, input logic [15:0] d, input logic c);
    wr = w; rd = r; din = d; clr = c;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  // Behavioural reference: a queue plus sticky flags.
  logic [15:0] mq[$];
  logic        m_ovf, m_udf;

  task automatic check_state(input string tag);
    chk({tag, " level"}, 32'(level), 32'(mq.size()));
    chk({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, " full"},  32'(full),  32'(mq.size() == DEPTH));
    chk({tag, " afull"}, 32'(afull), 32'(mq.size() >= DEPTH - 4));
    chk({tag, " ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, " udf"},   32'(udf),   32'(m_udf));
    if (mq.size() != 0) chk({tag, " dout"}, 32'(dout), 32'(mq[0]));
  endtask

  task automatic mcyc(input string tag, input logic w, input logic r,
                      input logic [15:0] d, input logic c);
    bit pop, push, oe, ue;
    pop  = r && (mq.size() != 0);
    push = w && ((mq.size() < DEPTH) || pop);
    oe   = w && (mq.size() == DEPTH) && !pop;
    ue   = r && (mq.size() == 0);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(d);
    m_ovf = oe | (m_ovf & ~c);
    m_udf = ue | (m_udf & ~c);
    drive(w, r, d, c);
    check_state(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = '0;
    bp_en = 1'b0; bp_period = '0;
    m_ovf = 1'b0; m_udf = 1'b0;

    // Single-cycle vectors starting from an empty FIFO with clear flags.
    tbl[0] = mk(1, 1, 0, 16'h1234, 7'd1, 0, 1, 0, 1, 16'h1234); // wr+rd on empty
    tbl[1] = mk(1, 0, 0, 16'hA5A5, 7'd2, 0, 1, 0, 1, 16'h1234);
    tbl[2] = mk(0, 0, 1, 16'h0000, 7'd2, 0, 0, 0, 1, 16'h1234); // clear udf
    tbl[3] = mk(0, 1, 0, 16'h0000, 7'd1, 0, 0, 0, 1, 16'hA5A5);
    tbl[4] = mk(1, 1, 0, 16'h5555, 7'd1, 0, 0, 0, 1, 16'h5555); // push+pop
    tbl[5] = mk(0, 1, 0, 16'h0000, 7'd0, 1, 0, 0, 0, 16'h0000);
    tbl[6] = mk(0, 1, 1, 16'h0000, 7'd0, 1, 1, 0, 0, 16'h0000); // event beats clear
    tbl[7] = mk(0, 0, 1, 16'h0000, 7'd0, 1, 0, 0, 0, 16'h0000);
    tbl[8] = mk(1, 0, 0, 16'hC0DE, 7'd1, 0, 0, 0, 1, 16'hC0DE);

    // Reset with requests active: they must be ignored.
    wr = 1'b1; rd = 1'b1; din = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    chk("rst level", 32'(level), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full",  32'(full),  0);
    chk("rst afull", 32'(afull), 0);
    chk("rst ovf",   32'(ovf),   0);
    chk("rst udf",   32'(udf),   0);
    chk("rst tick",  32'(tick),  0);
    wr = 1'b0; rd = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst empty", 32'(empty), 1);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].din, tbl[i].clr);
      chk($sformatf("vec%0d level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("vec%0d udf", i),   32'(udf),   32'(tbl[i].udf));
      chk($sformatf("vec%0d ovf", i),   32'(ovf),   32'(tbl[i].ovf));
      if (tbl[i].dchk) chk($sformatf("vec%0d dout", i), 32'(dout), 32'(tbl[i].dout));
    end

    // Fill to full, then overflow.
    do_reset();
    for (int i = 1; i <= 64; i++) mcyc($sformatf("fill%0d", i), 1'b1, 1'b0, 16'(i), 1'b0);
    chk("fill full",  32'(full),  1);
    chk("fill afull", 32'(afull), 1);
    chk("fill level", 32'(level), 64);
    mcyc("ovf", 1'b1, 1'b0, 16'hBEEF, 1'b0);
    chk("ovf flag", 32'(ovf), 1);

    // Drain with rd held high, then underflow.
    for (int i = 1; i <= 64; i++) begin
      chk($sformatf("drain head%0d", i), 32'(dout), 32'(i));
      mcyc($sformatf("drain%0d", i), 1'b0, 1'b1, 16'h0000, 1'b0);
    end
    chk("drain empty", 32'(empty), 1);
    mcyc("udf", 1'b0, 1'b1, 16'h0000, 1'b0);
    chk("udf flag", 32'(udf), 1);

    // Streaming through a full FIFO, across pointer wrap.
    mcyc("clr", 1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 64; i++) mcyc("refill", 1'b1, 1'b0, 16'(16'h0100 + i), 1'b0);
    for (int k = 0; k < 70; k++) begin
      mcyc($sformatf("stream%0d", k), 1'b1, 1'b1, 16'(16'h2000 + k), 1'b0);
      if (k == 63) chk("stream emerge", 32'(dout), 32'h2000);
    end
    chk("stream level", 32'(level), 64);
    chk("stream ovf",   32'(ovf),   0);

    // Tick generator.
    do_reset();
    bp_period = 16'd4; bp_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      chk($sformatf("tick P4 e%0d", i), 32'(tick), 32'((i % 5) == 4));
    end
    bp_period = 16'd1;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      chk($sformatf("tick P1 e%0d", j), 32'(tick), 32'((j % 2) == 0));
    end
    bp_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      chk($sformatf("tick off e%0d", j), 32'(tick), 0);
    end
    bp_period = 16'd0; bp_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      chk($sformatf("tick P0 e%0d", j), 32'(tick), 1);
    end

    // Reset in the middle of operation with level 10 and ovf set.
    bp_period = 16'd2;
    for (int i = 0; i < 65; i++) mcyc("pre-rst fill", 1'b1, 1'b0, 16'(16'h3000 + i), 1'b0);
    for (int i = 0; i < 54; i++) mcyc("pre-rst pop", 1'b0, 1'b1, 16'h0000, 1'b0);
    chk("pre-rst level", 32'(level), 10);
    chk("pre-rst ovf",   32'(ovf),   1);
    rst = 1'b1; wr = 1'b1; rd = 1'b1; din = 16'hFFFF;
    @(posedge clk); #1;
    chk("midrst level", 32'(level), 0);
    chk("midrst empty", 32'(empty), 1);
    chk("midrst ovf",   32'(ovf),   0);
    chk("midrst udf",   32'(udf),   0);
    chk("midrst tick",  32'(tick),  0);
    rst = 1'b0; wr = 1'b0; rd = 1'b0; bp_en = 1'b0;
    @(posedge clk); #1;
    chk("after midrst empty", 32'(empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sfifo_buf.md
SFIFO_BUF -- requirements
Module: sfifo_buf

Interface
REQ-001 SHALL have parameter SFIFO_DW, default 16, meaning data width of one FIFO word.
REQ-002 SHALL have parameter AW, default 6, meaning address width; depth DEPTH = 2**AW words.
REQ-003 SHALL have parameter AF_MARGIN, default 4, meaning the almost-full threshold offset from DEPTH.
REQ-004 SHALL have parameter BP_W, default 16, meaning width of the base-period divider.
REQ-005 SHALL use one clock and a synchronous, active-high reset, on the ports below.
REQ-006 wb_clk_i  input  1  sole clock; all state changes on rising edge.
REQ-007 wb_rst_i  input  1  synchronous active-high reset.
REQ-008 wr_i  input  1  write request from producer.
REQ-009 din_i  input  SFIFO_DW  write data.
REQ-010 full_o  output  1  FIFO holds DEPTH words.
REQ-011 afull_o  output  1  level_o >= DEPTH-AF_MARGIN.
REQ-012 rd_i  input  1  read/pop request from consumer.
REQ-013 empty_o  output  1  FIFO holds 0 words.
REQ-014 dout_o  output  SFIFO_DW  head word, first-word-fall-through.
REQ-015 level_o  output  AW+1  current word count, 0..DEPTH.
REQ-016 ovf_o  output  1  sticky overflow flag.
REQ-017 udf_o  output  1  sticky underflow flag.
REQ-018 clr_err_i  input  1  clears ovf_o and udf_o.
REQ-019 bp_en_i  input  1  enables base-period tick generator.
REQ-020 bp_period_i  input  BP_W  tick period minus one, in clocks.
REQ-021 bp_tick_o  output  1  one-clock base-period pulse.

Function
REQ-022 SHALL present the oldest stored word on dout_o whenever empty_o=0, with no read latency; the consumer samples dout_o and asserts rd_i to pop it.
REQ-023 dout_o SHALL be don't-care while empty_o=1.
REQ-024 A pop SHALL occur when rd_i=1 and empty_o=0; the next word (if any) appears on dout_o the following cycle.
REQ-025 A push SHALL occur when wr_i=1 and either full_o=0 or a pop occurs in the same cycle.
REQ-026 On a simultaneous push and pop, level_o SHALL be unchanged, and both operations SHALL complete.
REQ-027 A push into an empty FIFO SHALL deassert empty_o and present din_i on dout_o on the next cycle.
REQ-028 rd_i=1 with empty_o=1 SHALL pop nothing and set udf_o, even if wr_i=1 that cycle; the write is still accepted.
REQ-029 wr_i=1 with full_o=1 and no pop SHALL drop the word, leave the contents unchanged, and set ovf_o.
REQ-030 Read and write pointers SHALL be AW bits and wrap from DEPTH-1 to 0.
REQ-031 level_o, full_o, empty_o and afull_o SHALL be registered and reflect the operations of the previous cycle.
REQ-032 ovf_o and udf_o SHALL remain set until clr_err_i=1 or reset.
REQ-033 If clr_err_i and a new error event occur in the same cycle, the flag SHALL end up set.
REQ-034 Tick generator SHALL use a BP_W-bit counter.
  - bp_en_i=0: counter held at 0, bp_tick_o=0.
  - bp_en_i=1: counter increments each clock.
  - When counter >= bp_period_i: bp_tick_o=1 for that cycle and the counter returns to 0 on the next cycle.
REQ-035 With a constant bp_period_i=P, bp_tick_o SHALL pulse once every P+1 clocks; P=0 SHALL give a tick every clock.
REQ-036 bp_tick_o SHALL be registered, so the first tick appears P+1 clocks after bp_en_i rises.
REQ-037 Lowering bp_period_i below the current count SHALL produce a tick on the next cycle; there SHALL be no counter wrap-around.
REQ-038 Memory SHALL be inferable as a simple dual-port RAM: one write port, one read address.

Reset
REQ-039 While wb_rst_i=1, the block SHALL drive:
  - pointers and level_o = 0, empty_o=1, full_o=0, afull_o=0;
  - ovf_o=0, udf_o=0;
  - tick counter = 0, bp_tick_o=0.
REQ-040 Reset mid-operation SHALL discard all stored words; memory contents need not be cleared.
REQ-041 wr_i and rd_i SHALL be ignored during the reset cycle.

Verification
REQ-042 Write 0x0001..0x0040 (64 words, AW=6), no reads -> after last write full_o=1, afull_o=1, level_o=64; a 65th write of 0xBEEF sets ovf_o and the contents are unchanged.
REQ-043 Drain after REQ-042 with rd_i held high -> dout_o sequence 0x0001..0x0040; empty_o=1 after 64 pops; one extra rd_i sets udf_o.
REQ-044 Full FIFO plus simultaneous wr_i/rd_i -> level_o stays 64, ovf_o stays 0, and the written word emerges after 63 further pops; repeat across pointer wrap.
REQ-045 Empty FIFO, wr_i=1 din_i=0x1234 with rd_i=1 the same cycle -> udf_o=1, next cycle empty_o=0 and dout_o=0x1234.
REQ-046 bp_en_i=1, bp_period_i=4 -> bp_tick_o high every 5th clock; change to 1 while count is 3 -> tick next cycle, then every 2 clocks; bp_en_i=0 -> no ticks.
REQ-047 Assert wb_rst_i with level_o=10 and ovf_o=1 -> next cycle level_o=0, empty_o=1, ovf_o=0, bp_tick_o=0.
